// File: rtl/jk_pkg.sv
// Shared types and constants for the JK excitation driver slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding and the JK excitation codes packed as {J,K}.
package jk_pkg;

    // 2'b11 is deliberately left unused; the FSM treats it as illegal.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        CHECK = 2'b10
    } state_t;

    // Excitation codes, packed as {J,K}.
    localparam logic [1:0] HOLD   = 2'b00;
    localparam logic [1:0] SET    = 2'b10;
    localparam logic [1:0] RESET  = 2'b01;
    localparam logic [1:0] TOGGLE = 2'b11;

endpackage

// File: rtl/jk_excitation_driver_if.sv
// Target handshake plus flop-bank J/K/Q bundle for jk_excitation_driver.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready; source holds target/use_toggle until in_ready.
// Modports: master = target source / flop bank side, slave = the driver.
interface jk_excitation_driver_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] target;
    logic             use_toggle;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic             busy;
    logic             done;
    logic             match;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid, target, use_toggle, q_fb,
        input  in_ready, j_out, k_out, busy, done, match, err_count
    );

    modport slave (
        input  in_valid, target, use_toggle, q_fb,
        output in_ready, j_out, k_out, busy, done, match, err_count
    );
endinterface

// File: rtl/jk_excite_lut.sv
// One-bit JK excitation table: J/K needed to move a flop from q to t.
// Latency: combinational.
// Backpressure: none.
// Ports: q (current Q), t (wanted Q), use_toggle (J=K=1 for changing bits), j/k out.
module jk_excite_lut
    import jk_pkg::*;
(
    input  logic q,
    input  logic t,
    input  logic use_toggle,
    output logic j,
    output logic k
);
    logic [1:0] jk;

    // Don't-care entries of the table are resolved to 0 so unchanged bits
    // always see HOLD.
    always_comb begin
        jk = HOLD;
        if (q != t) begin
            if (use_toggle) begin
                jk = TOGGLE;
            end else if (t) begin
                jk = SET;
            end else begin
                jk = RESET;
            end
        end
    end

    assign j = jk[1];
    assign k = jk[0];
endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a bank of WIDTH JK flops toward a requested target word, then verifies Q.
// Latency: accept at edge N, J/K held through N..N+1, done/match at edge N+2.
// Backpressure: in_ready high only in IDLE; one target per 3 cycles.
// Ports: c/reset (async active-high), bus = slave side of jk_excitation_driver_if
//        (target handshake, q_fb in, registered j_out/k_out, busy/done/match/err_count).
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input  logic                   c,
    input  logic                   reset,
    jk_excitation_driver_if.slave  bus
);
    state_t           state;
    logic [WIDTH-1:0] tgt_r;
    logic [WIDTH-1:0] j_r;
    logic [WIDTH-1:0] k_r;
    logic [WIDTH-1:0] j_next;
    logic [WIDTH-1:0] k_next;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             match_r;
    logic [ERR_W-1:0] err_r;
    logic             check_ok;

    // Per-bit excitation from live Q and the offered target; only consumed
    // on the accepting edge.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lut
        jk_excite_lut u_lut (
            .q          (bus.q_fb[i]),
            .t          (bus.target[i]),
            .use_toggle (bus.use_toggle),
            .j          (j_next[i]),
            .k          (k_next[i])
        );
    end

    assign check_ok = (bus.q_fb == tgt_r);

    always_ff @(posedge c or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tgt_r   <= '0;
            j_r     <= '0;
            k_r     <= '0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            match_r <= 1'b0;
            err_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        tgt_r   <= bus.target;
                        j_r     <= j_next;
                        k_r     <= k_next;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state   <= DRIVE;
                    end else begin
                        j_r <= '0;
                        k_r <= '0;
                    end
                end
                DRIVE: begin
                    // Flops capture J/K on this edge; release them right away
                    // so nothing is re-applied during CHECK.
                    j_r   <= '0;
                    k_r   <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    match_r <= check_ok;
                    done_r  <= 1'b1;
                    if (!check_ok && (err_r != {ERR_W{1'b1}})) begin
                        err_r <= err_r + 1'b1;
                    end
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    // Illegal encoding: recover to a quiet IDLE.
                    j_r     <= '0;
                    k_r     <= '0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = ready_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.match     = match_r;
    assign bus.err_count = err_r;
    assign bus.j_out     = j_r;
    assign bus.k_out     = k_r;
endmodule

// File: tb/tb_jk_excitation_driver.sv
module tb_jk_excitation_driver;
    localparam int WIDTH = 4;
    localparam int ERR_W = 8;

    typedef struct {
        logic [WIDTH-1:0] j;
        logic [WIDTH-1:0] k;
        logic             match;
        logic [ERR_W-1:0] err;
    } exp_t;

    logic c;
    logic reset;
    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] stuck0;
    logic [ERR_W-1:0] exp_err;
    int               cycle;
    int               total;
    int               bad;
    exp_t             exp_q[$];

    jk_excitation_driver_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

    jk_excitation_driver #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
        .c     (c),
        .reset (reset),
        .bus   (bus)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    always @(posedge c) cycle <= cycle + 1;

    // Behavioural JK flop bank; stuck0 forces selected Q feedback bits low.
    always @(posedge c or posedge reset) begin
        if (reset) bank_q <= '0;
        else       bank_q <= (bus.j_out & ~bank_q) | (~bus.k_out & bank_q);
    end
    assign bus.q_fb = bank_q & ~stuck0;

    // Predict J/K, the post-update check result and the error count.
    task automatic push_exp(input logic [WIDTH-1:0] tgt, input logic tog);
        exp_t e;
        logic [WIDTH-1:0] qf, diff, nq;
        qf   = bus.q_fb;
        diff = qf ^ tgt;
        e.j  = tog ? diff : (~qf & tgt);
        e.k  = tog ? diff : (qf & ~tgt);
        nq   = (e.j & ~bank_q) | (~e.k & bank_q);
        e.match = ((nq & ~stuck0) == tgt);
        if (!e.match && exp_err != {ERR_W{1'b1}}) exp_err = exp_err + 1'b1;
        e.err = exp_err;
        exp_q.push_back(e);
    endtask

    // One full transfer with exact-latency checks; returns observed J/K.
    task automatic drive_one(input logic [WIDTH-1:0] tgt, input logic tog,
                             output logic [WIDTH-1:0] oj, output logic [WIDTH-1:0] ok);
        exp_t e;
        int n;
        n = 0;
        @(negedge c);
        while (!bus.in_ready && n < 20) begin
            @(negedge c);
            n++;
        end
        if (!bus.in_ready) begin
            total++; bad++;
            $display("FAIL ready_timeout in_ready=%b required=1", bus.in_ready);
        end
        bus.in_valid   = 1'b1;
        bus.target     = tgt;
        bus.use_toggle = tog;
        push_exp(tgt, tog);
        @(posedge c); #1;
        bus.in_valid = 1'b0;
        oj = bus.j_out;
        ok = bus.k_out;
        e = exp_q[exp_q.size()-1];
        total++;
        if (bus.j_out !== e.j || bus.k_out !== e.k) begin
            bad++;
            $display("FAIL drive_jk j=%b k=%b required j=%b k=%b", bus.j_out, bus.k_out, e.j, e.k);
        end
        total++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL drive_flags busy=%b in_ready=%b done=%b required 1/0/0",
                     bus.busy, bus.in_ready, bus.done);
        end
        @(posedge c); #1;
        total++;
        if (bus.j_out !== '0 || bus.k_out !== '0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL check_phase j=%b k=%b busy=%b done=%b required 0/0/1/0",
                     bus.j_out, bus.k_out, bus.busy, bus.done);
        end
        @(posedge c); #1;
        e = exp_q.pop_front();
        total++;
        if (bus.done !== 1'b1 || bus.match !== e.match || bus.err_count !== e.err) begin
            bad++;
            $display("FAIL result done=%b match=%b err=%0d required 1/%b/%0d",
                     bus.done, bus.match, bus.err_count, e.match, e.err);
        end
        total++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL back_idle in_ready=%b busy=%b required 1/0", bus.in_ready, bus.busy);
        end
        @(posedge c); #1;
        total++;
        if (bus.done !== 1'b0 || bus.match !== e.match) begin
            bad++;
            $display("FAIL done_pulse done=%b match=%b required 0/%b", bus.done, bus.match, e.match);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #23;
        total++;
        if (bus.j_out !== '0 || bus.k_out !== '0 || bus.done !== 1'b0 || bus.match !== 1'b0 ||
            bus.err_count !== '0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state j=%b k=%b done=%b match=%b err=%0d busy=%b rdy=%b required 0/0/0/0/0/0/1",
                     bus.j_out, bus.k_out, bus.done, bus.match, bus.err_count, bus.busy, bus.in_ready);
        end
        @(negedge c);
        reset = 1'b0;
        repeat (2) @(negedge c);
        total++;
        if (bus.j_out !== '0 || bus.k_out !== '0 || bus.in_ready !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold j=%b k=%b rdy=%b done=%b required 0/0/1/0",
                     bus.j_out, bus.k_out, bus.in_ready, bus.done);
        end
    endtask

    task automatic test_set_bits;
        logic [WIDTH-1:0] oj, ok;
        drive_one(4'b1010, 1'b0, oj, ok);
        total++;
        if (oj !== 4'b1010 || ok !== 4'b0000 || bank_q !== 4'b1010) begin
            bad++;
            $display("FAIL set_bits j=%b k=%b q=%b required 1010/0000/1010", oj, ok, bank_q);
        end
    endtask

    task automatic test_set_reset_mix;
        logic [WIDTH-1:0] oj, ok;
        drive_one(4'b0110, 1'b0, oj, ok);
        total++;
        if (oj !== 4'b0100 || ok !== 4'b1000 || bank_q !== 4'b0110) begin
            bad++;
            $display("FAIL set_reset_mix j=%b k=%b q=%b required 0100/1000/0110", oj, ok, bank_q);
        end
    endtask

    task automatic test_toggle;
        logic [WIDTH-1:0] oj, ok;
        drive_one(4'b1001, 1'b1, oj, ok);
        total++;
        if (oj !== 4'b1111 || ok !== 4'b1111 || bank_q !== 4'b1001) begin
            bad++;
            $display("FAIL toggle j=%b k=%b q=%b required 1111/1111/1001", oj, ok, bank_q);
        end
    endtask

    task automatic test_stuck_saturate;
        logic [WIDTH-1:0] oj, ok;
        stuck0 = 4'b0001;
        drive_one(4'b1111, 1'b0, oj, ok);
        total++;
        if (bus.match !== 1'b0 || bus.err_count !== 8'd1) begin
            bad++;
            $display("FAIL stuck_first match=%b err=%0d required 0/1", bus.match, bus.err_count);
        end
        for (int i = 1; i < 300; i++) drive_one(4'b1111, 1'b0, oj, ok);
        total++;
        if (bus.err_count !== 8'd255) begin
            bad++;
            $display("FAIL err_saturate err=%0d required 255", bus.err_count);
        end
        stuck0 = '0;
    endtask

    task automatic test_back_to_back;
        int seen;
        int last_acc;
        seen = 0;
        last_acc = 0;
        @(negedge c);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    int n;
                    logic [WIDTH-1:0] pat;
                    pat = i[0] ? 4'b1111 : 4'b0000;
                    bus.in_valid   = 1'b1;
                    bus.target     = pat;
                    bus.use_toggle = 1'b0;
                    n = 0;
                    while (!bus.in_ready && n < 10) begin
                        @(negedge c);
                        n++;
                    end
                    push_exp(pat, 1'b0);
                    @(posedge c); #1;
                    if (i > 0) begin
                        total++;
                        if (cycle - last_acc != 3) begin
                            bad++;
                            $display("FAIL b2b_spacing gap=%0d required 3", cycle - last_acc);
                        end
                    end
                    last_acc = cycle;
                    total++;
                    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                        bad++;
                        $display("FAIL b2b_busy rdy=%b busy=%b required 0/1", bus.in_ready, bus.busy);
                    end
                    @(posedge c); #1;
                    total++;
                    if (bus.in_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL b2b_check_rdy rdy=%b required 0", bus.in_ready);
                    end
                    @(negedge c);
                end
                bus.in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 40 && seen < 6; k++) begin
                    @(posedge c); #2;
                    if (bus.done) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        seen++;
                        total++;
                        if (bus.match !== e.match || bus.err_count !== e.err) begin
                            bad++;
                            $display("FAIL b2b_result match=%b err=%0d required %b/%0d",
                                     bus.match, bus.err_count, e.match, e.err);
                        end
                    end
                end
                total++;
                if (seen != 6) begin
                    bad++;
                    $display("FAIL b2b_count results=%0d required 6", seen);
                end
            end
        join
    endtask

    task automatic test_reset_mid_drive;
        int pulses;
        @(negedge c);
        bus.in_valid   = 1'b1;
        bus.target     = ~bus.q_fb;
        bus.use_toggle = 1'b0;
        @(posedge c); #1;
        bus.in_valid = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || (bus.j_out | bus.k_out) !== 4'b1111) begin
            bad++;
            $display("FAIL mid_drive_entry busy=%b jk=%b required 1/1111", bus.busy, bus.j_out | bus.k_out);
        end
        #2;
        reset = 1'b1;
        exp_err = '0;
        #1;
        total++;
        if (bus.j_out !== '0 || bus.k_out !== '0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL async_abort j=%b k=%b rdy=%b busy=%b required 0/0/1/0",
                     bus.j_out, bus.k_out, bus.in_ready, bus.busy);
        end
        @(negedge c);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge c); #1;
            if (bus.done) pulses++;
        end
        total++;
        if (pulses != 0 || bus.err_count !== exp_err || bus.match !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_quiet pulses=%0d err=%0d match=%b rdy=%b required 0/%0d/0/1",
                     pulses, bus.err_count, bus.match, bus.in_ready, exp_err);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        cycle = 0;
        exp_err = '0;
        stuck0 = '0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.target = '0;
        bus.use_toggle = 1'b0;
        test_reset();
        test_set_bits();
        test_set_reset_mix();
        test_toggle();
        test_stuck_saturate();
        test_back_to_back();
        test_reset_mid_drive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
